force_release_ctrl: RTL and testbench

- Parametrised, clocked force/release controller for the force/release emulation flow.
- Replaces a single hard-wired forced net with N independent W-bit channels.
- Each channel passes its functional value through unless forced. A force holds indefinitely until release, or for a programmable number of cycles before auto-release.
- Sits between functional drivers and their loads in the emulation top; all state is in one clock domain.

---
 rtl/force_release_pkg.sv | 20 ++
 rtl/force_release_chan.sv | 78 +++++++
 rtl/force_release_ctrl.sv | 53 +++++
 tb/tb_force_release_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/force_release_pkg.sv
`default_nettype none
// ============================================================================
// Module      : force_release_pkg
// Description : Shared types and constants for the force/release controller.
// Revision    : 1.0 - initial release
// ============================================================================
package force_release_pkg;

  // Per-channel controller state
  typedef enum logic [1:0] {
    FR_IDLE  = 2'd0,  // functional pass-through
    FR_HELD  = 2'd1,  // forced until an explicit release
    FR_TIMED = 2'd2   // forced for a counted number of cycles
  } fr_state_e;

  // A hold length of zero requests an indefinite force
  localparam int FR_HOLD_INDEF = 0;

endpackage : force_release_pkg
`default_nettype wire

// File: rtl/force_release_chan.sv
`default_nettype none
// ============================================================================
// Module      : force_release_chan
// Description : One force/release channel: state machine, hold counter,
//               captured force value and the output mux.
// Revision    : 1.0 - initial release
// ============================================================================
module force_release_chan
  import force_release_pkg::*;
#(
  parameter int W        = 8,
  parameter int CNT_W    = 8,
  parameter int LIVE_VAL = 0
) (
  input  logic             i_sclk,
  input  logic             i_srst,
  input  logic [W-1:0]     i_func,
  input  logic [W-1:0]     i_force_val,
  input  logic             i_force,
  input  logic             i_release,
  input  logic [CNT_W-1:0] i_hold,
  output logic [W-1:0]     o_val,
  output logic             o_forced,
  output logic             o_expired
);

  fr_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     cap;
  logic             expired;
  logic [W-1:0]     force_src;

  // Channel FSM: release has priority, then force (which also retriggers),
  // then the timed countdown that auto-releases when the count reaches one.
  always_ff @(posedge i_sclk or negedge i_srst) begin
    if (!i_srst) begin
      state   <= FR_IDLE;
      cnt     <= '0;
      cap     <= '0;
      expired <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (i_release) begin
        // Captured value is intentionally kept; it is simply not selected.
        state <= FR_IDLE;
      end else if (i_force) begin
        cap <= i_force_val;
        cnt <= i_hold;
        if (i_hold == CNT_W'(FR_HOLD_INDEF)) begin
          state <= FR_HELD;
        end else begin
          state <= FR_TIMED;
        end
      end else if (state == FR_TIMED) begin
        // The count is never zero while timed; the <= guard keeps it from wrapping.
        if (cnt <= CNT_W'(1)) begin
          state   <= FR_IDLE;
          cnt     <= '0;
          expired <= 1'b1;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
      end
    end
  end

  // Output mux driven only by registered state, so force/release requests
  // never reach o_val combinationally.
  always_comb begin
    force_src = (LIVE_VAL != 0) ? i_force_val : cap;
    o_val     = (state != FR_IDLE) ? force_src : i_func;
  end

  assign o_forced  = (state != FR_IDLE);
  assign o_expired = expired;

endmodule : force_release_chan
`default_nettype wire

// File: rtl/force_release_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : force_release_ctrl
// Description : N independent W-bit force/release channels placed between
//               functional drivers and their loads.
// Revision    : 1.0 - initial release
// ============================================================================
module force_release_ctrl
  import force_release_pkg::*;
#(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int CNT_W    = 8,
  parameter int LIVE_VAL = 0
) (
  input  logic             i_sclk,
  input  logic             i_srst,
  input  logic [N*W-1:0]   i_func,
  input  logic [N*W-1:0]   i_force_val,
  input  logic [N-1:0]     i_force,
  input  logic [N-1:0]     i_release,
  input  logic [CNT_W-1:0] i_hold,
  output logic [N*W-1:0]   o_val,
  output logic [N-1:0]     o_forced,
  output logic [N-1:0]     o_expired,
  output logic             o_any_forced
);

  // One channel per lane; the shared hold length is sampled by whichever
  // channels see a force request in the same cycle.
  for (genvar k = 0; k < N; k++) begin : g_chan
    force_release_chan #(
      .W        (W),
      .CNT_W    (CNT_W),
      .LIVE_VAL (LIVE_VAL)
    ) u_chan (
      .i_sclk      (i_sclk),
      .i_srst      (i_srst),
      .i_func      (i_func[k*W +: W]),
      .i_force_val (i_force_val[k*W +: W]),
      .i_force     (i_force[k]),
      .i_release   (i_release[k]),
      .i_hold      (i_hold),
      .o_val       (o_val[k*W +: W]),
      .o_forced    (o_forced[k]),
      .o_expired   (o_expired[k])
    );
  end

  assign o_any_forced = |o_forced;

endmodule : force_release_ctrl
`default_nettype wire

// File: tb/tb_force_release_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_force_release_ctrl
// Description : Directed self-checking bench for force_release_ctrl, with a
//               latched-value instance and a live-value instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_force_release_ctrl;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N*W-1:0]   func;
  logic [N*W-1:0]   fval;
  logic [N-1:0]     frc;
  logic [N-1:0]     rel;
  logic [CNT_W-1:0] hold;

  logic [N*W-1:0]   val;
  logic [N-1:0]     forced;
  logic [N-1:0]     expired;
  logic             any_forced;

  logic [N*W-1:0]   val_l;
  logic [N-1:0]     forced_l;
  logic [N-1:0]     expired_l;
  logic             any_forced_l;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  force_release_ctrl #(.N(N), .W(W), .CNT_W(CNT_W), .LIVE_VAL(0)) dut (
    .i_sclk(clk), .i_srst(rst_n), .i_func(func), .i_force_val(fval),
    .i_force(frc), .i_release(rel), .i_hold(hold),
    .o_val(val), .o_forced(forced), .o_expired(expired), .o_any_forced(any_forced)
  );

  force_release_ctrl #(.N(N), .W(W), .CNT_W(CNT_W), .LIVE_VAL(1)) dut_live (
    .i_sclk(clk), .i_srst(rst_n), .i_func(func), .i_force_val(fval),
    .i_force(frc), .i_release(rel), .i_hold(hold),
    .o_val(val_l), .o_forced(forced_l), .o_expired(expired_l), .o_any_forced(any_forced_l)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ch(input logic [N*W-1:0] v, input int k);
    return v[k*W +: W];
  endfunction

  task automatic set_func(input int k, input logic [W-1:0] v);
    func[k*W +: W] = v;
  endtask

  task automatic set_fval(input int k, input logic [W-1:0] v);
    fval[k*W +: W] = v;
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    func  = '0;
    fval  = '0;
    frc   = '0;
    rel   = '0;
    hold  = '0;
    set_func(0, 8'h3C);
    set_func(1, 8'h21);
    set_func(2, 8'h42);
    set_func(3, 8'h83);
    #12;
    check("rst_val",        val, 32'h8342213C);
    check("rst_forced",     forced, 4'b0000);
    check("rst_any",        any_forced, 1'b0);
    check("rst_expired",    expired, 4'b0000);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Reset arriving in the middle of a timed force
    set_fval(2, 8'h77); hold = 8'd10; frc = 4'b0100;
    tick();
    frc = '0; hold = '0;
    check("mid_timed_forced", forced, 4'b0100);
    check("mid_timed_val",    ch(val, 2), 8'h77);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_val",    ch(val, 2), 8'h42);
    check("async_rst_forced", forced, 4'b0000);
    check("async_rst_any",    any_forced, 1'b0);
    tick();
    tick();
    check("async_rst_noexp",  expired, 4'b0000);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Indefinite force on ch1 while its functional value toggles
    set_fval(1, 8'hA5); hold = 8'd0; frc = 4'b0010;
    tick();
    frc = '0;
    check("held_val",    ch(val, 1), 8'hA5);
    check("held_forced", forced, 4'b0010);
    check("held_any",    any_forced, 1'b1);
    for (int i = 0; i < 4; i++) begin
      set_func(1, 8'(8'h11 * i + 1));
      tick();
      check("held_toggle", {ch(val, 1), 4'(expired)}, {8'hA5, 4'b0000});
    end
    set_func(1, 8'h21);
    rel = 4'b0010;
    tick();
    rel = '0;
    check("held_release_val", ch(val, 1), 8'h21);
    check("held_release_frc", forced, 4'b0000);
    check("held_release_exp", expired, 4'b0000);

    // Timed force hold=3 on ch2: three forced cycles, then pulse
    set_fval(2, 8'h55); hold = 8'd3; frc = 4'b0100;
    tick();
    frc = '0; hold = '0;
    for (int i = 0; i < 3; i++) begin
      check("timed_val", {ch(val, 2), 4'(expired)}, {8'h55, 4'b0000});
      tick();
    end
    check("timed_end_val", ch(val, 2), 8'h42);
    check("timed_end_exp", expired, 4'b0100);
    check("timed_end_frc", forced, 4'b0000);
    tick();
    check("timed_pulse_1cy", expired, 4'b0000);

    // Force and release together: release wins
    set_fval(3, 8'hEE); frc = 4'b1000; rel = 4'b1000;
    tick();
    frc = '0; rel = '0;
    check("conflict_frc", forced, 4'b0000);
    check("conflict_val", ch(val, 3), 8'h83);

    // Retrigger: hold=5 replaced at 2nd forced cycle by 0x11 hold=2
    set_fval(3, 8'h66); hold = 8'd5; frc = 4'b1000;
    tick();
    frc = '0; hold = '0;
    check("retrig_1st", ch(val, 3), 8'h66);
    tick();
    check("retrig_2nd", ch(val, 3), 8'h66);
    set_fval(3, 8'h11); hold = 8'd2; frc = 4'b1000;
    tick();
    frc = '0; hold = '0;
    check("retrig_new1", {ch(val, 3), 4'(forced)}, {8'h11, 4'b1000});
    tick();
    check("retrig_new2", {ch(val, 3), 4'(expired)}, {8'h11, 4'b0000});
    tick();
    check("retrig_exp_val", ch(val, 3), 8'h83);
    check("retrig_exp",     {4'(expired), 4'(forced)}, {4'b1000, 4'b0000});

    // Parallel: ch3 held, ch0..2 timed together, then staggered expiries
    set_fval(3, 8'h99); hold = 8'd0; frc = 4'b1000;
    tick();
    set_fval(0, 8'hD0); set_fval(1, 8'hD1); set_fval(2, 8'hD2);
    hold = 8'd2; frc = 4'b0111;
    tick();
    frc = '0; hold = '0;
    check("par_val", val, 32'h99D2D1D0);
    tick();
    check("par_noexp", expired, 4'b0000);
    tick();
    check("par_exp_all", {4'(expired), 4'(forced), 1'(any_forced)}, {4'b0111, 4'b1000, 1'b1});
    hold = 8'd1; frc = 4'b0001;
    tick();
    frc = 4'b0010;
    tick();
    check("stag_exp0", expired, 4'b0001);
    frc = 4'b0100;
    tick();
    check("stag_exp1", expired, 4'b0010);
    frc = '0; hold = '0;
    tick();
    check("stag_exp2", expired, 4'b0100);
    tick();
    check("stag_done", {4'(expired), 4'(forced), 1'(any_forced)}, {4'b0000, 4'b1000, 1'b1});
    rel = 4'b1000;
    tick();
    rel = '0;
    check("par_release_any", {4'(forced), 1'(any_forced)}, {4'b0000, 1'b0});

    // Maximum hold length counts down without wrapping
    set_fval(1, 8'hC3); hold = 8'd255; frc = 4'b0010;
    tick();
    frc = '0; hold = '0;
    n = 0;
    while (forced[1] && n < 300) begin
      n++;
      tick();
    end
    check("max_hold_len", n, 255);
    check("max_hold_exp", expired, 4'b0010);

    // Live-value instance tracks i_force_val; latched one keeps its capture
    set_fval(0, 8'h00); hold = 8'd0; frc = 4'b0001;
    tick();
    frc = '0;
    for (int v = 0; v < 8; v++) begin
      set_fval(0, 8'(v));
      #1;
      check("live_track", ch(val_l, 0), 32'(v));
    end
    check("latched_hold", ch(val, 0), 8'h00);
    rel = 4'b0001;
    tick();
    rel = '0;
    check("live_release", {ch(val_l, 0), 4'(forced_l)}, {8'h3C, 4'b0000});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_force_release_ctrl
`default_nettype wire
